// File: rtl/addsub_accumulator.sv
// rtl/addsub_accumulator.sv - burst add/sub accumulator with sticky signed overflow; optional SATURATE_EN clamps on overflow
module addsub_accumulator #(
  parameter int WIDTH     = 8,
  parameter int BURST_LEN = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_cin,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] acc_out,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             ovf,
  output logic             busy
);

  localparam int CNT_W = $clog2(BURST_LEN) + 1;
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BURST_LEN - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [WIDTH-1:0] acc;
  logic             ovf_q;
  logic [CNT_W-1:0] count;

  logic             beat;
  logic [WIDTH-1:0] sum;
  logic             beat_ovf;
  logic [WIDTH-1:0] acc_beat;

  // Operand arrives pre-inverted for subtraction; the carry-in completes the negation.
  assign beat     = in_valid && (state == ACCUM);
  assign sum      = acc + in_data + {{(WIDTH-1){1'b0}}, in_cin};
  assign beat_ovf = (acc[WIDTH-1] == in_data[WIDTH-1]) && (sum[WIDTH-1] != acc[WIDTH-1]);

`ifdef SATURATE_EN
  // Clamp toward the sign shared by both operands when the sum leaves the signed range.
  assign acc_beat = !beat_ovf     ? sum :
                    acc[WIDTH-1]  ? {1'b1, {(WIDTH-1){1'b0}}} :
                                    {1'b0, {(WIDTH-1){1'b1}}};
`else
  assign acc_beat = sum;
`endif

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state and state-decoded handshake outputs.
  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          state_nxt = ACCUM;
        end
      end
      ACCUM: begin
        in_ready = 1'b1;
        busy     = 1'b1;
        if (beat && (count == LAST_BEAT)) begin
          state_nxt = DONE;
        end
      end
      DONE: begin
        out_valid = 1'b1;
        busy      = 1'b1;
        if (out_ready) begin
          state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Accumulator, sticky overflow and beat counter; result stays visible in IDLE until next start.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc   <= '0;
      ovf_q <= 1'b0;
      count <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            acc   <= '0;
            ovf_q <= 1'b0;
            count <= '0;
          end
        end
        ACCUM: begin
          if (beat) begin
            acc   <= acc_beat;
            count <= count + 1'b1;
            if (beat_ovf) begin
              ovf_q <= 1'b1;
            end
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign acc_out = acc;
  assign ovf     = ovf_q;

endmodule

// File: tb/tb_addsub_accumulator.sv
// tb/tb_addsub_accumulator.sv - self-checking bench for addsub_accumulator
module tb_addsub_accumulator;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic [7:0] in_data = 8'h00;
  logic       in_cin = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [7:0] acc_out;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic       ovf;
  logic       busy;

  int total = 0;
  int bad   = 0;

  int m_acc;
  bit m_ovf;

  addsub_accumulator #(.WIDTH(8), .BURST_LEN(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .in_data   (in_data),
    .in_cin    (in_cin),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .acc_out   (acc_out),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .ovf       (ovf),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: got=timeout want=finish");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic drive_beat(input logic [7:0] d, input logic c);
    in_valid = 1'b1;
    in_data  = d;
    in_cin   = c;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic drive_handshake();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  // Signed-integer reference: the result is the true sum clamped or wrapped into [-128,127].
  function automatic void model_beat(input logic [7:0] d, input logic c);
    int sd;
    int s;
    sd = $signed(d);
    s  = m_acc + sd + int'(c);
    if (s > 127 || s < -128) begin
      m_ovf = 1'b1;
`ifdef SATURATE_EN
      s = (s > 127) ? 127 : -128;
`else
      while (s > 127)  s = s - 256;
      while (s < -128) s = s + 256;
`endif
    end
    m_acc = s;
  endfunction

  task automatic test_reset();
    rst = 1'b1; start = 1'b1; in_valid = 1'b1; in_data = 8'h55; out_ready = 1'b1;
    tick();
    tick();
    rst = 1'b0; start = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    total++;
    if ({in_ready, out_valid, busy, ovf} !== 4'b0000) begin
      bad++; $display("FAIL reset_flags got=%b want=0000", {in_ready, out_valid, busy, ovf});
    end
    total++;
    if (acc_out !== 8'h00) begin
      bad++; $display("FAIL reset_acc got=%h want=00", acc_out);
    end
  endtask

  task automatic test_directed();
    logic [7:0] dd [3][4];
    logic       cc [3][4];
    logic [7:0] exp_acc [3];
    dd = '{'{8'h05, 8'h03, 8'hFD, 8'h01}, '{8'h70, 8'h20, 8'h00, 8'h00}, '{8'h80, 8'hFE, 8'h00, 8'h00}};
    cc = '{'{1'b0, 1'b0, 1'b1, 1'b0}, '{1'b0, 1'b0, 1'b0, 1'b0}, '{1'b0, 1'b1, 1'b0, 1'b0}};
`ifdef SATURATE_EN
    exp_acc = '{8'h07, 8'h7F, 8'h80};
`else
    exp_acc = '{8'h07, 8'h90, 8'h7F};
`endif
    for (int t = 0; t < 3; t++) begin
      drive_start();
      total++;
      if ({in_ready, out_valid, busy} !== 3'b101) begin
        bad++; $display("FAIL t%0d_accum_flags got=%b want=101", t + 1, {in_ready, out_valid, busy});
      end
      for (int i = 0; i < 4; i++) begin
        drive_beat(dd[t][i], cc[t][i]);
        total++;
        if (out_valid !== (i == 3)) begin
          bad++; $display("FAIL t%0d_out_valid_beat%0d got=%b want=%b", t + 1, i, out_valid, i == 3);
        end
      end
      total++;
      if (acc_out !== exp_acc[t]) begin
        bad++; $display("FAIL t%0d_acc got=%h want=%h", t + 1, acc_out, exp_acc[t]);
      end
      total++;
      if (ovf !== (t != 0)) begin
        bad++; $display("FAIL t%0d_ovf got=%b want=%b", t + 1, ovf, t != 0);
      end
      drive_handshake();
      total++;
      if ({busy, out_valid, acc_out} !== {2'b00, exp_acc[t]}) begin
        bad++; $display("FAIL t%0d_idle got=%b_%b_%h want=0_0_%h", t + 1, busy, out_valid, acc_out, exp_acc[t]);
      end
    end
  endtask

  task automatic test_hold();
    drive_start();
    drive_beat(8'h05, 1'b0);
    drive_beat(8'h03, 1'b0);
    drive_beat(8'hFD, 1'b1);
    drive_beat(8'h01, 1'b0);
    for (int i = 0; i < 5; i++) begin
      start = i[0];
      tick();
      total++;
      if ({out_valid, in_ready, busy, acc_out} !== {3'b101, 8'h07}) begin
        bad++; $display("FAIL t4_hold%0d got=%b%b%b_%h want=101_07", i, out_valid, in_ready, busy, acc_out);
      end
    end
    start = 1'b1;
    out_ready = 1'b1;
    tick();
    start = 1'b0;
    out_ready = 1'b0;
    total++;
    if ({busy, out_valid, in_ready} !== 3'b000) begin
      bad++; $display("FAIL t4_start_on_handshake got=%b want=000", {busy, out_valid, in_ready});
    end
    tick();
    total++;
    if ({busy, acc_out} !== {1'b0, 8'h07}) begin
      bad++; $display("FAIL t4_idle_keep got=%b_%h want=0_07", busy, acc_out);
    end
  endtask

  task automatic test_gaps();
    logic [6:0] pat;
    int beats;
    pat = 7'b1011001;
    beats = 0;
    drive_start();
    in_data = 8'h01;
    in_cin  = 1'b0;
    for (int i = 6; i >= 0; i--) begin
      in_valid = pat[i];
      tick();
      if (pat[i]) beats++;
      total++;
      if ({out_valid, in_ready} !== {beats == 4, beats < 4}) begin
        bad++; $display("FAIL t5_step%0d got=%b%b want=%b%b", 6 - i, out_valid, in_ready, beats == 4, beats < 4);
      end
    end
    in_valid = 1'b0;
    total++;
    if ({acc_out, ovf} !== {8'h04, 1'b0}) begin
      bad++; $display("FAIL t5_result got=%h_%b want=04_0", acc_out, ovf);
    end
    drive_handshake();
  endtask

  task automatic test_midburst_reset();
    drive_start();
    drive_beat(8'h70, 1'b0);
    drive_beat(8'h20, 1'b0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    total++;
    if ({acc_out, ovf, in_ready, out_valid, busy} !== {8'h00, 4'b0000}) begin
      bad++; $display("FAIL t6_reset got=%h_%b%b%b%b want=00_0000", acc_out, ovf, in_ready, out_valid, busy);
    end
    drive_start();
    drive_beat(8'h05, 1'b0);
    drive_beat(8'h03, 1'b0);
    drive_beat(8'hFD, 1'b1);
    drive_beat(8'h01, 1'b0);
    total++;
    if ({out_valid, acc_out, ovf} !== {1'b1, 8'h07, 1'b0}) begin
      bad++; $display("FAIL t6_fresh got=%b_%h_%b want=1_07_0", out_valid, acc_out, ovf);
    end
    drive_handshake();
  endtask

  task automatic test_random();
    int beats;
    int cyc;
    bit v;
    logic [7:0] ea;
    for (int b = 0; b < 25; b++) begin
      drive_start();
      m_acc = 0;
      m_ovf = 1'b0;
      beats = 0;
      cyc = 0;
      while (beats < 4 && cyc < 100) begin
        v        = ($urandom_range(0, 2) != 0);
        in_valid = v;
        in_data  = 8'($urandom);
        in_cin   = 1'($urandom);
        start    = ($urandom_range(0, 7) == 0);
        tick();
        cyc++;
        if (v) begin
          model_beat(in_data, in_cin);
          beats++;
        end
        ea = m_acc[7:0];
        total++;
        if ({acc_out, ovf, in_ready, out_valid} !== {ea, m_ovf, beats < 4, beats == 4}) begin
          bad++; $display("FAIL rnd%0d_cyc%0d got=%h_%b%b%b want=%h_%b%b%b", b, cyc, acc_out, ovf, in_ready, out_valid, ea, m_ovf, beats < 4, beats == 4);
        end
      end
      in_valid = 1'b0;
      start = 1'b0;
      if (beats < 4) begin
        total++; bad++; $display("FAIL rnd%0d_budget got=%0d want=4", b, beats);
      end
      for (int w = 0; w < int'($urandom_range(0, 3)); w++) begin
        start = 1'($urandom);
        tick();
        total++;
        if ({out_valid, acc_out} !== {1'b1, ea}) begin
          bad++; $display("FAIL rnd%0d_hold got=%b_%h want=1_%h", b, out_valid, acc_out, ea);
        end
      end
      start = 1'b0;
      drive_handshake();
      total++;
      if ({busy, acc_out, ovf} !== {1'b0, ea, m_ovf}) begin
        bad++; $display("FAIL rnd%0d_idle got=%b_%h_%b want=0_%h_%b", b, busy, acc_out, ovf, ea, m_ovf);
      end
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_hold();
    test_gaps();
    test_midburst_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
